// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and digit-count helpers for serial_adder_n
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int ndig(input int w, input int d);
    return w / d;
  endfunction
  function automatic int cnt_w(input int w, input int d);
    return ndig(w, d) > 1 ? $clog2(ndig(w, d)) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_n_if.sv
// serial_adder_n_if: operand/result handshake bundle; ovf exists only with SERIAL_ADDER_OVF_EN
interface serial_adder_n_if #(parameter int WIDTH = 128);
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [WIDTH-1:0] a, b, s;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
`endif
  modport master(
    output in_valid, a, b, cin, sub, out_ready,
    input in_ready, out_valid, s, cout
`ifdef SERIAL_ADDER_OVF_EN
    , ovf
`endif
  );
  modport slave(
    input in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout
`ifdef SERIAL_ADDER_OVF_EN
    , ovf
`endif
  );
endinterface

// File: rtl/digit_add.sv
// digit_add: combinational DIGIT-bit ripple adder; MSB carry-in output only with SERIAL_ADDER_OVF_EN
module digit_add #(parameter int DIGIT = 8) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  , output logic           cm
`endif
);
  logic [DIGIT:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (.x(x[i]), .y(y[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end
  assign co = c[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
  assign cm = c[DIGIT-1];
`endif
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n: digit-serial add/sub, one DIGIT slice per clock LSB first; SERIAL_ADDER_OVF_EN adds signed overflow
module serial_adder_n
  import adder_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DIGIT = 8
) (
  input logic clk,
  input logic rst,
  serial_adder_n_if.slave bus
);
  localparam int ND = ndig(WIDTH, DIGIT);
  localparam int KW = cnt_w(WIDTH, DIGIT);
  localparam logic [KW-1:0] LAST = KW'(ND - 1);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, s_r;
  logic [KW-1:0] k;
  logic [DIGIT-1:0] sum;
  logic carry, co, out_v, accept, fire;
`ifdef SERIAL_ADDER_OVF_EN
  logic cm, ovf_r;
`endif
  assign bus.in_ready  = state == IDLE && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign fire          = out_v && bus.out_ready;
  assign bus.out_valid = out_v;
  assign bus.s         = s_r;
  assign bus.cout      = carry;
  digit_add #(.DIGIT(DIGIT)) u_add (
    .x(a_sr[DIGIT-1:0]), .y(b_sr[DIGIT-1:0]), .ci(carry), .sum(sum), .co(co)
`ifdef SERIAL_ADDER_OVF_EN
    , .cm(cm)
`endif
  );
  // next state: accept -> RUN for NDIG digits -> DONE until the result is taken
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? RUN : IDLE) :
              state == RUN  ? (k == LAST ? DONE : RUN) :
                              (fire ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // operand shifters, carry, result slices; out_valid rises one cycle into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_r   <= '0;
      carry <= 1'b0;
      k     <= '0;
      out_v <= 1'b0;
    end else begin
      out_v <= state == DONE && !fire;
      if (accept) begin
        a_sr  <= bus.a;
        b_sr  <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.cin ^ bus.sub;
        k     <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> DIGIT;
        b_sr  <= b_sr >> DIGIT;
        s_r[k*DIGIT +: DIGIT] <= sum;
        carry <= co;
        k     <= k + 1'b1;
      end
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf = ovf_r;
  // signed overflow from the MSB carries of the final digit
  always_ff @(posedge clk) begin
    if (rst) ovf_r <= 1'b0;
    else if (state == RUN && k == LAST) ovf_r <= cm ^ co;
  end
`endif
endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: scoreboard bench for serial_adder_n (128/8 and 32/32 builds; ovf cases with SERIAL_ADDER_OVF_EN)
module tb_serial_adder_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_n_if #(.WIDTH(128)) if0 ();
  serial_adder_n_if #(.WIDTH(32))  if1 ();
  serial_adder_n #(.WIDTH(128), .DIGIT(8))  dut0 (.clk(clk), .rst(rst), .bus(if0));
  serial_adder_n #(.WIDTH(32),  .DIGIT(32)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct { logic [127:0] s; logic cout; logic ovf; } exp_t;
  exp_t sb[$];
  int pass_n = 0;
  int total_n = 0;

  task automatic send(input logic [127:0] a, input logic [127:0] b, input logic cin, input logic sub);
    exp_t e;
    logic [127:0] bx;
    logic [128:0] r;
    int n;
    bx = sub ? ~b : b;
    r = {1'b0, a} + {1'b0, bx} + 129'(cin ^ sub);
    e.s = r[127:0];
    e.cout = r[128];
    e.ovf = (a[127] == bx[127]) && (r[127] != a[127]);
    sb.push_back(e);
    if0.a = a; if0.b = b; if0.cin = cin; if0.sub = sub; if0.in_valid = 1'b1;
    n = 0;
    while (if0.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 0; ok = 0;
    while (lat < 100 && !ok) begin @(posedge clk); #1; lat++; ok = (if0.out_valid === 1'b1); end
  endtask

  task automatic take();
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total_n++; if (if0.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", if0.out_valid); else pass_n++;
    total_n++; if (if0.s !== 128'd0) $display("FAIL rst_s got %h want 0", if0.s); else pass_n++;
    total_n++; if (if0.cout !== 1'b0) $display("FAIL rst_cout got %b want 0", if0.cout); else pass_n++;
    total_n++; if (if0.in_ready !== 1'b0) $display("FAIL rst_in_ready_hi got %b want 0", if0.in_ready); else pass_n++;
    total_n++; if (if1.out_valid !== 1'b0) $display("FAIL rst1_out_valid got %b want 0", if1.out_valid); else pass_n++;
    rst = 1'b0;
    #1;
    total_n++; if (if0.in_ready !== 1'b1) $display("FAIL rst_in_ready_lo got %b want 1", if0.in_ready); else pass_n++;
  endtask

  task automatic test_increment_wrap();
    exp_t e; int lat; bit ok;
    send({128{1'b1}}, 128'd0, 1'b1, 1'b0);
    wait_out(lat, ok);
    e = sb.pop_front();
    total_n++; if (!ok || lat != 17) $display("FAIL inc_latency got %0d want 17", lat); else pass_n++;
    total_n++; if (if0.s !== e.s) $display("FAIL inc_s got %h want %h", if0.s, e.s); else pass_n++;
    total_n++; if (if0.cout !== e.cout) $display("FAIL inc_cout got %b want %b", if0.cout, e.cout); else pass_n++;
    take();
  endtask

  task automatic test_subtract();
    exp_t e; int lat; bit ok;
    send(128'd5, 128'd7, 1'b0, 1'b1);
    wait_out(lat, ok);
    e = sb.pop_front();
    total_n++; if (!ok) $display("FAIL sub1_timeout got %0d cycles want out_valid", lat); else pass_n++;
    total_n++; if (if0.s !== e.s) $display("FAIL sub1_s got %h want %h", if0.s, e.s); else pass_n++;
    total_n++; if (if0.cout !== e.cout) $display("FAIL sub1_cout got %b want %b", if0.cout, e.cout); else pass_n++;
    take();
    send(128'd7, 128'd5, 1'b0, 1'b1);
    wait_out(lat, ok);
    e = sb.pop_front();
    total_n++; if (!ok) $display("FAIL sub2_timeout got %0d cycles want out_valid", lat); else pass_n++;
    total_n++; if (if0.s !== e.s) $display("FAIL sub2_s got %h want %h", if0.s, e.s); else pass_n++;
    total_n++; if (if0.cout !== e.cout) $display("FAIL sub2_cout got %b want %b", if0.cout, e.cout); else pass_n++;
    take();
  endtask

  task automatic test_backpressure();
    exp_t e; int lat; bit ok;
    send(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, 1'b0);
    wait_out(lat, ok);
    e = sb.pop_front();
    total_n++; if (!ok) $display("FAIL bp_timeout got %0d cycles want out_valid", lat); else pass_n++;
    for (int i = 0; i < 5; i++) begin
      total_n++;
      if (if0.out_valid !== 1'b1 || if0.s !== e.s || if0.cout !== e.cout || if0.in_ready !== 1'b0)
        $display("FAIL bp_hold cycle %0d got v=%b s=%h c=%b r=%b want v=1 s=%h c=%b r=0", i, if0.out_valid, if0.s, if0.cout, if0.in_ready, e.s, e.cout);
      else pass_n++;
      @(posedge clk); #1;
    end
    take();
    total_n++; if (if0.in_ready !== 1'b1) $display("FAIL bp_in_ready got %b want 1", if0.in_ready); else pass_n++;
    total_n++; if (if0.out_valid !== 1'b0) $display("FAIL bp_out_valid_drop got %b want 0", if0.out_valid); else pass_n++;
  endtask

  task automatic test_reset_mid_run();
    exp_t e; int lat; bit ok; int seen;
    send(128'hffff, 128'h1, 1'b0, 1'b0);
    void'(sb.pop_back());
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total_n++; if (if0.out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", if0.out_valid); else pass_n++;
    total_n++; if (if0.s !== 128'd0) $display("FAIL mid_s got %h want 0", if0.s); else pass_n++;
    total_n++; if (if0.in_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", if0.in_ready); else pass_n++;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (if0.out_valid === 1'b1) seen++; end
    total_n++; if (seen != 0) $display("FAIL mid_discard got %0d valid cycles want 0", seen); else pass_n++;
    send(128'h1234, 128'h0001, 1'b0, 1'b0);
    wait_out(lat, ok);
    e = sb.pop_front();
    total_n++; if (!ok) $display("FAIL mid_new_timeout got %0d cycles want out_valid", lat); else pass_n++;
    total_n++; if (if0.s !== e.s) $display("FAIL mid_new_s got %h want %h", if0.s, e.s); else pass_n++;
    take();
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; bit ok;
    logic [127:0] a, b;
    logic cin, sub;
    if0.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      send(a, b, cin, sub);
      wait_out(lat, ok);
      e = sb.pop_front();
      total_n++;
      if (!ok || lat != 17 || if0.s !== e.s || if0.cout !== e.cout)
        $display("FAIL b2b_%0d got lat=%0d s=%h c=%b want lat=17 s=%h c=%b", i, lat, if0.s, if0.cout, e.s, e.cout);
      else pass_n++;
    end
    @(posedge clk); #1;
    if0.out_ready = 1'b0;
  endtask

  task automatic test_single_digit();
    int lat; bit ok;
    if1.a = 32'hFFFF_0000; if1.b = 32'h0001_0000; if1.cin = 1'b0; if1.sub = 1'b0; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    lat = 0; ok = 0;
    while (lat < 20 && !ok) begin @(posedge clk); #1; lat++; ok = (if1.out_valid === 1'b1); end
    total_n++; if (!ok || lat != 2) $display("FAIL one_latency got %0d want 2", lat); else pass_n++;
    total_n++; if (if1.s !== 32'd0) $display("FAIL one_s got %h want 0", if1.s); else pass_n++;
    total_n++; if (if1.cout !== 1'b1) $display("FAIL one_cout got %b want 1", if1.cout); else pass_n++;
    if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.out_ready = 1'b0;
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    exp_t e; int lat; bit ok;
    send({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0);
    wait_out(lat, ok);
    e = sb.pop_front();
    total_n++; if (!ok || if0.ovf !== e.ovf || if0.cout !== e.cout) $display("FAIL ovf_pos got ovf=%b c=%b want ovf=%b c=%b", if0.ovf, if0.cout, e.ovf, e.cout); else pass_n++;
    take();
    send({128{1'b1}}, 128'd1, 1'b0, 1'b0);
    wait_out(lat, ok);
    e = sb.pop_front();
    total_n++; if (!ok || if0.ovf !== e.ovf || if0.cout !== e.cout) $display("FAIL ovf_neg got ovf=%b c=%b want ovf=%b c=%b", if0.ovf, if0.cout, e.ovf, e.cout); else pass_n++;
    take();
  endtask
`endif

  initial begin
    if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.cin = 1'b0; if0.sub = 1'b0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.sub = 1'b0; if1.out_ready = 1'b0;
    test_reset();
    test_increment_wrap();
    test_subtract();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_single_digit();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
